pe_sys_mac_pipe: RTL

//   Parametrised fixed-point processing element for the systolic weight-stationary array; successor of the float PE.

---
 rtl/pe_sys_mac_pipe.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pe_sys_mac_pipe.sv
// -----------------------------------------------------------------------------
// pe_sys_mac_pipe
//   Fixed-point processing element for a weight-stationary systolic array.
//   It has a 2-stage datapath with four modes (MAC, L1 distance, squared L2
//   distance, bypass), double-buffered weights and optional accumulate
//   saturation with a sticky flag.
//
//   Token protocol: a token is the bundle {act_in, sum_in, MODE} qualified by
//   act_in_valid. There is no backpressure. The bundle is captured on every
//   rising CLK edge where EN=1. act_out/act_out_valid repeat it one edge later.
//   sum_out/sum_out_valid carry its result two edges later. Invalid tokens
//   still flow through the pipe with valid=0. Their sum_out value is
//   meaningless and they never touch sat_flag. While EN=0 nothing is
//   captured and every register holds.
//
// Ports
//   CLK, RESET        clock; synchronous active-high reset (wins over all)
//   EN                1: advance, 0: stall (W_EN/W_SWAP/CLR_SAT ignored)
//   MODE              00 MAC, 01 L1, 10 L2, 11 BYPASS (per token)
//   act_in_valid      token valid
//   act_in            signed activation from the left neighbour
//   sum_in            signed partial sum from the PE above
//   act_out_valid     act_in_valid delayed one cycle
//   act_out           act_in delayed one cycle (to right neighbour)
//   sum_out_valid     valid for sum_out (two-cycle latency)
//   sum_out           partial sum to the PE below
//   W_EN, weight_in   load weight_in into the shadow bank
//   W_SWAP            copy the shadow bank into the active bank
//   weight_out        shadow bank (column shift chain, one cycle per PE)
//   CLR_SAT           clear sat_flag (a same-edge saturation wins)
//   sat_flag          sticky saturation indicator
// -----------------------------------------------------------------------------
module pe_sys_mac_pipe #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 24,
  parameter bit SATURATE = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              EN,
  input  logic [1:0]        MODE,
  input  logic              act_in_valid,
  input  logic [DATA_W-1:0] act_in,
  input  logic [ACC_W-1:0]  sum_in,
  output logic              act_out_valid,
  output logic [DATA_W-1:0] act_out,
  output logic              sum_out_valid,
  output logic [ACC_W-1:0]  sum_out,
  input  logic              W_EN,
  input  logic              W_SWAP,
  input  logic [DATA_W-1:0] weight_in,
  output logic [DATA_W-1:0] weight_out,
  input  logic              CLR_SAT,
  output logic              sat_flag
);

  localparam logic [1:0] MODE_MAC = 2'b00;
  localparam logic [1:0] MODE_L1  = 2'b01;
  localparam logic [1:0] MODE_L2  = 2'b10;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Weight banks
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [DATA_W-1:0] active_q, active_d;

  // Stage 1 registers: token tag, forwarded sum and computed term
  logic                     s1_valid_q;
  logic [ACC_W-1:0]         s1_sum_q;
  logic signed [ACC_W:0]    s1_term_q, term_d;

  // Activation forwarding
  logic                     act_valid_q;
  logic [DATA_W-1:0]        act_q;

  // Stage 2 registers
  logic                     sum_valid_q;
  logic [ACC_W-1:0]         sum_q, sum_d;
  logic                     sat_q, sat_d;

  // ---------------------------------------------------------------------------
  // Stage 1 term generation. The operands are widened before any arithmetic,
  // so no intermediate result can overflow.
  // ---------------------------------------------------------------------------
  logic signed [2*DATA_W-1:0] act_x, w_x, prod_s;
  logic signed [DATA_W:0]     act_d1, w_d1, diff_s;
  logic [DATA_W:0]            abs_u;
  logic [2*DATA_W+1:0]        abs_x, sq_u;

  assign act_x  = (2*DATA_W)'($signed(act_in));
  assign w_x    = (2*DATA_W)'($signed(active_q));
  assign prod_s = act_x * w_x;

  assign act_d1 = (DATA_W+1)'($signed(act_in));
  assign w_d1   = (DATA_W+1)'($signed(active_q));
  assign diff_s = act_d1 - w_d1;
  // The magnitude is unsigned on DATA_W+1 bits, so |-2^DATA_W| is representable.
  assign abs_u  = diff_s[DATA_W] ? -diff_s : diff_s;
  assign abs_x  = (2*DATA_W+2)'(abs_u);
  assign sq_u   = abs_x * abs_x;

  always_comb begin
    term_d = '0;
    case (MODE)
      MODE_MAC: term_d = (ACC_W+1)'(prod_s);
      MODE_L1:  term_d = (ACC_W+1)'(abs_u);
      MODE_L2:  term_d = (ACC_W+1)'(sq_u);
      default:  term_d = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage 2 accumulate. The add is done on ACC_W+1 bits. The result overflows
  // the ACC_W signed range exactly when its top two bits differ.
  // ---------------------------------------------------------------------------
  logic signed [ACC_W:0] s1_sum_x, sum_ext;
  logic                  ovf;

  assign s1_sum_x = (ACC_W+1)'($signed(s1_sum_q));
  assign sum_ext  = s1_sum_x + s1_term_q;
  assign ovf      = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];

  always_comb begin
    sum_d = sum_ext[ACC_W-1:0];
    if (SATURATE && ovf) begin
      sum_d = sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  // Set has priority over clear on the same edge.
  assign sat_d = (sat_q & ~CLR_SAT) | (SATURATE & ovf & s1_valid_q);

  // Swap copies the pre-load shadow value when W_EN and W_SWAP share an edge.
  assign active_d = W_SWAP ? shadow_q : active_q;
  assign shadow_d = W_EN ? weight_in : shadow_q;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      shadow_q    <= '0;
      active_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      s1_term_q   <= '0;
      act_valid_q <= 1'b0;
      act_q       <= '0;
      sum_valid_q <= 1'b0;
      sum_q       <= '0;
      sat_q       <= 1'b0;
    end else if (EN) begin
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      s1_valid_q  <= act_in_valid;
      s1_sum_q    <= sum_in;
      s1_term_q   <= term_d;
      act_valid_q <= act_in_valid;
      act_q       <= act_in;
      sum_valid_q <= s1_valid_q;
      sum_q       <= sum_d;
      sat_q       <= sat_d;
    end
  end

  assign act_out_valid = act_valid_q;
  assign act_out       = act_q;
  assign sum_out_valid = sum_valid_q;
  assign sum_out       = sum_q;
  assign weight_out    = shadow_q;
  assign sat_flag      = sat_q;

endmodule
